flash_spi_reader: RTL and testbench

FLASH_SPI_READER -- requirements
Module: flash_spi_reader

---
 rtl/flash_spi_reader.sv | 131 +++++++++++++
 tb/tb_flash_spi_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_spi_reader.sv
// OBI-to-SPI bridge for reading 32-bit words from a serial NOR flash (READ 0x03, mode 0).
// Writes are rejected with an error response and never touch the SPI bus.
module flash_spi_reader #(
  parameter int unsigned ClkDiv  = 2,
  parameter int unsigned IdWidth = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               obi_req_i,
  output logic               obi_gnt_o,
  input  logic [31:0]        obi_addr_i,
  input  logic               obi_we_i,
  input  logic [3:0]         obi_be_i,
  input  logic [31:0]        obi_wdata_i,
  input  logic [IdWidth-1:0] obi_aid_i,
  output logic               obi_rvalid_o,
  output logic [31:0]        obi_rdata_o,
  output logic [IdWidth-1:0] obi_rid_o,
  output logic               obi_err_o,
  output logic               spi_sck_o,
  output logic               spi_csn_o,
  output logic               spi_mosi_o,
  input  logic               spi_miso_i
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, RESP} state_e;

  state_e              state, state_next;
  logic [7:0]          div_cnt;
  logic                phase;      // 0: sck low half, 1: sck high half
  logic [5:0]          bit_cnt;
  logic [31:0]         tx_sr;
  logic [31:0]         rx_sr;
  logic                we_q;
  logic [IdWidth-1:0]  aid_q;
  logic [31:0]         tx_word;
  logic                shifting, phase_end, bit_end;
  logic                unused;

  assign unused    = ^{obi_be_i, obi_wdata_i, obi_addr_i[31:24], obi_addr_i[1:0]};
  assign tx_word   = {8'h03, obi_addr_i[23:2], 2'b00};
  assign obi_gnt_o = obi_req_i && (state == IDLE);

  assign shifting  = (state == CMD || state == ADDR || state == DATA) && !we_q;
  assign phase_end = shifting && (div_cnt == 8'(ClkDiv - 1));
  assign bit_end   = phase_end && phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: defaulting every always_comb output first keeps paths that do not
  // assign it from inferring a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (obi_req_i) state_next = CMD;
      // A write spends one silent cycle here so its error lands two cycles after grant.
      CMD:  if (we_q) state_next = RESP;
            else if (bit_end && bit_cnt == 6'd7) state_next = ADDR;
      ADDR: if (bit_end && bit_cnt == 6'd31) state_next = DATA;
      DATA: if (bit_end && bit_cnt == 6'd63) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    obi_rvalid_o = 1'b0;
    obi_err_o    = 1'b0;
    obi_rdata_o  = '0;
    obi_rid_o    = '0;
    if (state == RESP) begin
      obi_rvalid_o = 1'b1;
      obi_err_o    = we_q;
      obi_rid_o    = aid_q;
      // First received byte is the lowest-addressed one: little-endian word.
      if (!we_q) obi_rdata_o = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spi_csn_o  <= 1'b1;
      spi_sck_o  <= 1'b0;
      spi_mosi_o <= 1'b0;
      div_cnt    <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      we_q       <= 1'b0;
      aid_q      <= '0;
    end else if (obi_gnt_o) begin
      we_q       <= obi_we_i;
      aid_q      <= obi_aid_i;
      spi_csn_o  <= obi_we_i;
      spi_sck_o  <= 1'b0;
      spi_mosi_o <= tx_word[31] & ~obi_we_i;
      tx_sr      <= tx_word << 1;
      div_cnt    <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
    end else if (shifting) begin
      if (phase_end) begin
        div_cnt   <= '0;
        phase     <= ~phase;
        spi_sck_o <= ~phase;
        if (!phase && state == DATA) rx_sr <= {rx_sr[30:0], spi_miso_i};
        if (phase) begin
          if (bit_cnt == 6'd63) begin
            bit_cnt    <= '0;
            spi_csn_o  <= 1'b1;
            spi_mosi_o <= 1'b0;
          end else begin
            // tx_sr fills with zeros, so MOSI idles low through the data phase.
            bit_cnt    <= bit_cnt + 6'd1;
            spi_mosi_o <= tx_sr[31];
            tx_sr      <= tx_sr << 1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_flash_spi_reader.sv
// Randomized scoreboard bench: two readers (ClkDiv 2 and 1) talk to a behavioural flash;
// expected responses are queued at grant and checked by an independent monitor.
module tb_flash_spi_reader;

  localparam int IDW  = 4;
  localparam int DIV0 = 2;
  localparam int DIV1 = 1;

  typedef struct {
    int              dut;
    int              due;
    logic [31:0]     rdata;
    logic            err;
    logic [IDW-1:0]  rid;
    logic            is_read;
    logic [23:0]     spi_addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic           req[2], we[2], gnt[2], rvalid[2], err[2];
  logic           sck[2], csn[2], mosi[2], miso[2];
  logic [31:0]    addr[2], rdata[2];
  logic [IDW-1:0] aid[2], rid[2];
  logic [3:0]     be = 4'hF;
  logic [31:0]    wdata = 32'hDEAD_BEEF;

  flash_spi_reader #(.ClkDiv(DIV0), .IdWidth(IDW)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .obi_req_i(req[0]), .obi_gnt_o(gnt[0]), .obi_addr_i(addr[0]), .obi_we_i(we[0]),
    .obi_be_i(be), .obi_wdata_i(wdata), .obi_aid_i(aid[0]),
    .obi_rvalid_o(rvalid[0]), .obi_rdata_o(rdata[0]), .obi_rid_o(rid[0]), .obi_err_o(err[0]),
    .spi_sck_o(sck[0]), .spi_csn_o(csn[0]), .spi_mosi_o(mosi[0]), .spi_miso_i(miso[0])
  );

  flash_spi_reader #(.ClkDiv(DIV1), .IdWidth(IDW)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .obi_req_i(req[1]), .obi_gnt_o(gnt[1]), .obi_addr_i(addr[1]), .obi_we_i(we[1]),
    .obi_be_i(be), .obi_wdata_i(wdata), .obi_aid_i(aid[1]),
    .obi_rvalid_o(rvalid[1]), .obi_rdata_o(rdata[1]), .obi_rid_o(rid[1]), .obi_err_o(err[1]),
    .spi_sck_o(sck[1]), .spi_csn_o(csn[1]), .spi_mosi_o(mosi[1]), .spi_miso_i(miso[1])
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [7:0] mem [4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int g);
    return (g == 0) ? DIV0 : DIV1;
  endfunction

  // Reference: what the flash word at the aligned address is, and when it must appear.
  function automatic exp_t model(input int g, input bit w, input logic [31:0] a,
                                 input logic [IDW-1:0] id, input int gcyc);
    exp_t e;
    int   idx;
    e.dut      = g;
    e.rid      = id;
    e.is_read  = !w;
    e.spi_addr = a[23:0] & 24'hFF_FFFC;
    if (w) begin
      e.err   = 1'b1;
      e.rdata = 32'h0;
      e.due   = gcyc + 2;
    end else begin
      idx     = int'(e.spi_addr[11:0]);
      e.err   = 1'b0;
      e.rdata = {mem[idx+3], mem[idx+2], mem[idx+1], mem[idx]};
      e.due   = gcyc + 1 + 128 * div_of(g);
    end
    return e;
  endfunction

  // Behavioural flash plus SPI protocol observer, sampled mid-cycle.
  int         n[2];
  int         hi_run[2];
  logic       prev_sck[2], prev_csn[2], prev_mosi[2];
  logic [31:0] sr[2];
  logic [7:0] last_cmd[2];
  logic [23:0] last_addr[2];

  initial begin
    for (int g = 0; g < 2; g++) begin
      n[g] = 0; hi_run[g] = 100; prev_sck[g] = 1'b0; prev_csn[g] = 1'b1;
      prev_mosi[g] = 1'b0; sr[g] = '0; last_cmd[g] = '0; last_addr[g] = '0; miso[g] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int         k;
      logic [7:0] b;
      if (!rst) begin
        if (!csn[g] && prev_csn[g]) check("csn_high_gap", 32'(hi_run[g] >= 2), 1);
        if (csn[g] && !prev_csn[g]) check("sck_low_at_csn_rise", sck[g], 0);
        if (!csn[g] && mosi[g] !== prev_mosi[g])
          check("mosi_change_at_low_start", !sck[g] && (prev_sck[g] || prev_csn[g]), 1);
      end
      if (csn[g]) begin
        n[g] = 0;
        miso[g] = 1'b0;
      end else if (sck[g] && !prev_sck[g]) begin
        if (n[g] < 32) sr[g] = {sr[g][30:0], mosi[g]};
        else check("mosi_zero_in_data", mosi[g], 0);
        n[g]++;
        if (n[g] == 32) begin
          last_cmd[g]  = sr[g][31:24];
          last_addr[g] = sr[g][23:0];
        end
      end else if (!sck[g] && prev_sck[g] && n[g] >= 32 && n[g] < 64) begin
        k       = n[g] - 32;
        b       = mem[(int'(last_addr[g][11:0]) + k / 8) & 12'hFFF];
        miso[g] = b[7 - k % 8];
      end
      hi_run[g]    = csn[g] ? hi_run[g] + 1 : 0;
      prev_sck[g]  = sck[g];
      prev_csn[g]  = csn[g];
      prev_mosi[g] = mosi[g];
    end
  end

  // Response monitor: pops the scoreboard whenever a DUT presents rvalid.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      exp_t e;
      if (rvalid[g]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", rvalid[g], 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_dut", g, e.dut);
          check("rvalid_cycle", cycle, e.due);
          check("rdata", rdata[g], e.rdata);
          check("err", err[g], e.err);
          check("rid", rid[g], e.rid);
          if (e.is_read) begin
            check("spi_cmd", last_cmd[g], 8'h03);
            check("spi_addr", last_addr[g], e.spi_addr);
            check("csn_high_at_rvalid", csn[g], 1);
            check("sck_low_at_rvalid", sck[g], 0);
          end
        end
      end
    end
  end

  task automatic issue(input int g, input bit w, input logic [31:0] a,
                       input logic [IDW-1:0] id, output int gcyc);
    int waited = 0;
    req[g] = 1'b1; we[g] = w; addr[g] = a; aid[g] = id;
    #1;
    while (!gnt[g] && waited < 2000) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!gnt[g]) begin
      check("grant_timeout", gnt[g], 1);
      gcyc = -1;
    end else begin
      gcyc = cycle;
      exp_q.push_back(model(g, w, a, id, gcyc));
    end
    @(negedge clk); #1;
    if (gcyc >= 0) begin
      check(w ? "csn_idle_after_write" : "csn_fall", csn[g], w);
      check("sck_low_after_grant", sck[g], 0);
    end
  endtask

  task automatic release_req(input int g);
    req[g] = 1'b0; we[g] = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_txn(input int g);
    int gc;
    bit w = ($urandom_range(3) == 0);
    issue(g, w, $urandom(), IDW'($urandom()), gc);
    release_req(g);
    repeat ($urandom_range(3)) @(negedge clk);
    drain();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc, gc2;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom());
    mem[12'h104] = 8'h11; mem[12'h105] = 8'h22; mem[12'h106] = 8'h33; mem[12'h107] = 8'h44;
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; we[g] = 1'b0; addr[g] = '0; aid[g] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rst_gnt", gnt[g], 0);
      check("rst_csn", csn[g], 1);
      check("rst_sck", sck[g], 0);
      check("rst_mosi", mosi[g], 0);
      check("rst_rvalid", rvalid[g], 0);
      check("rst_err", err[g], 0);
      check("rst_rdata", rdata[g], 0);
      check("rst_rid", rid[g], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Known word, then an unaligned address that must fetch the same word.
    issue(0, 1'b0, 32'h2000_0104, 4'h5, gc); release_req(0); drain();
    issue(0, 1'b0, 32'h2000_0107, 4'hA, gc); release_req(0); drain();

    // Write is rejected without SPI traffic.
    issue(0, 1'b1, 32'h2000_0000, 4'h3, gc); release_req(0);
    for (int i = 0; i < 3; i++) begin
      check("csn_during_write", csn[0], 1);
      check("sck_during_write", sck[0], 0);
      @(negedge clk); #1;
    end
    drain();

    // Back-to-back reads with req held high.
    issue(0, 1'b0, 32'h0000_0A30, 4'h1, gc);
    issue(0, 1'b0, 32'h1234_5678, 4'h2, gc2);
    release_req(0);
    check("b2b_grant_gap", gc2 - gc, 1 + 128 * DIV0 + 1);
    drain();

    // Reset in the middle of a read aborts it silently.
    issue(0, 1'b0, 32'h0000_0200, 4'h7, gc); release_req(0);
    while (cycle < gc + 100) @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk); #1;
    check("abort_csn", csn[0], 1);
    check("abort_sck", sck[0], 0);
    check("abort_rvalid", rvalid[0], 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    issue(0, 1'b0, 32'h0000_0FFC, 4'hC, gc); release_req(0); drain();

    for (int i = 0; i < 6; i++) rand_txn(0);

    // Fastest divider.
    issue(1, 1'b0, 32'h2000_0104, 4'h6, gc); release_req(1); drain();
    for (int i = 0; i < 5; i++) rand_txn(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
